i8080_fetch_unit: RTL and testbench

- Parametrised instruction fetch front end for the 8080 core.
- Replaces the fixed "pc <= pc+2" word fetch with a byte-wide prefetch queue and 8080 length decode.
- Presents whole 1-, 2- and 3-byte instructions to decode with a valid/ready handshake.
- Supports PC redirect for jumps, calls, returns, RST and PCHL, with queue flush.

---
 rtl/i8080_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_i8080_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i8080_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : i8080_fetch_unit
// Purpose  : Byte-wide prefetch front end for the 8080 core. Bytes are read
//            one at a time into a small shift queue. The head byte is length
//            decoded, and whole 1/2/3-byte instructions are handed to decode
//            over a valid/ready handshake. A PC redirect flushes the queue.
//            Read data already in flight when the redirect happens is dropped
//            by an epoch tag.
// Ports    : clk, rst_n            clock / async active-low reset
//            mem_rd_en, mem_addr   byte read request (one in flight at most)
//            mem_rdata             read data, one cycle after the request
//            redir_valid/redir_pc  load new PC and flush
//            ins_valid/ins_ready   instruction handshake
//            ins_opcode/imm/len/pc presented instruction
//            halted                fetch stopped on HLT (optional feature)
// Options  : I8080_FETCH_HLT_STOP_EN - when defined, accepting HLT (0x76)
//            stops fetch until the next redirect or reset.
// Revision : 1.0 - initial release
// ============================================================================
module i8080_fetch_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [7:0]        ins_opcode,
  output logic [15:0]       ins_imm,
  output logic [1:0]        ins_len,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted
);

  localparam int unsigned       CNT_W      = $clog2(QDEPTH + 1);
  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [CNT_W:0]    C_QDEPTH   = (CNT_W + 1)'(QDEPTH);

  logic [7:0]        r_q [QDEPTH];
  logic [7:0]        w_q_next [QDEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic [CNT_W-1:0]  w_wr_idx;
  logic [CNT_W:0]    w_occ;
  logic              r_inflight;
  logic              r_inflight_epoch;
  logic              r_epoch;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_head_pc;
  logic [1:0]        w_len;
  logic [1:0]        w_pop_n;
  logic              w_pop;
  logic              w_push;
  logic              w_halted;

  // 8080 instruction length from the opcode byte.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    if (((op & 8'hCF) == 8'h01) ||                       // LXI rp
        (op == 8'h22) || (op == 8'h2A) ||                // SHLD / LHLD
        (op == 8'h32) || (op == 8'h3A) ||                // STA / LDA
        (op == 8'hC3) || (op == 8'hCB) ||                // JMP (+alias)
        ((op & 8'hC7) == 8'hC2) ||                       // Jccc
        ((op & 8'hCF) == 8'hCD) ||                       // CALL + aliases
        ((op & 8'hC7) == 8'hC4))                         // Cccc
      len = 2'd3;
    else if (((op & 8'hC7) == 8'h06) ||                  // MVI r
             ((op & 8'hC7) == 8'hC6) ||                  // ALU immediate
             (op == 8'hDB) || (op == 8'hD3))             // IN / OUT
      len = 2'd2;
    return len;
  endfunction

  assign w_len      = decode_len(r_q[0]);
  assign ins_valid  = !w_halted && (r_count >= CNT_W'(w_len));
  assign ins_opcode = r_q[0];
  assign ins_len    = w_len;
  assign ins_pc     = r_head_pc;
  assign halted     = w_halted;

  always_comb begin
    ins_imm = 16'h0000;
    case (w_len)
      2'd3:    ins_imm = {r_q[2], r_q[1]};
      2'd2:    ins_imm = {8'h00, r_q[1]};
      default: ins_imm = 16'h0000;
    endcase
  end

  // Issue is based on registered occupancy only, so a pop in this cycle
  // does not open a slot until the next one. Gating with rst_n keeps the
  // request low while reset is held; the first request goes out in the
  // first cycle after release.
  assign w_occ     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign mem_rd_en = rst_n && !w_halted && (w_occ < C_QDEPTH);
  assign mem_addr  = r_fetch_pc;

  // Returned data is kept only if no redirect happened since it was issued.
  assign w_push   = r_inflight && (r_inflight_epoch == r_epoch) && !w_halted;
  assign w_pop    = ins_valid && ins_ready;
  assign w_pop_n  = w_pop ? w_len : 2'd0;
  assign w_wr_idx = r_count - CNT_W'(w_pop_n);

  // Shift the queue down by the popped length and write the returning byte
  // just past the surviving entries.
  always_comb begin
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if ((i + int'(w_pop_n)) < int'(QDEPTH))
        w_q_next[i] = r_q[i + int'(w_pop_n)];
      else
        w_q_next[i] = r_q[i];
      if (w_push && (i == int'(w_wr_idx)))
        w_q_next[i] = mem_rdata;
    end
  end

  assign w_count_next = r_count - CNT_W'(w_pop_n) + CNT_W'(w_push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) r_q[i] <= 8'h00;
      r_count          <= '0;
      r_inflight       <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_epoch          <= 1'b0;
      r_fetch_pc       <= C_RESET_PC;
      r_head_pc        <= C_RESET_PC;
    end else begin
      r_q              <= w_q_next;
      r_inflight       <= mem_rd_en;
      r_inflight_epoch <= r_epoch;
      if (redir_valid) begin
        r_count    <= '0;
        r_fetch_pc <= redir_pc;
        r_head_pc  <= redir_pc;
        r_epoch    <= ~r_epoch;
      end else begin
        r_count <= w_count_next;
        if (mem_rd_en) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        if (w_pop)     r_head_pc  <= r_head_pc + ADDR_W'(w_len);
      end
    end
  end

`ifdef I8080_FETCH_HLT_STOP_EN
  logic r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_halted <= 1'b0;
    else if (redir_valid)
      r_halted <= 1'b0;
    else if (w_pop && (r_q[0] == 8'h76))
      r_halted <= 1'b1;
  end

  assign w_halted = r_halted;
`else
  assign w_halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i8080_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_i8080_fetch_unit
// Purpose  : Self-checking bench for i8080_fetch_unit. A byte-queue reference
//            model predicts every output each cycle from the fetch rules.
//            Directed phases pin the model with literal expectations, and a
//            randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i8080_fetch_unit;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_pc = 16'h0000;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [7:0]  ins_opcode;
  logic [15:0] ins_imm;
  logic [1:0]  ins_len;
  logic [15:0] ins_pc;
  logic        halted;

  always #5 clk = ~clk;

  i8080_fetch_unit #(.ADDR_W(16), .QDEPTH(QD), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_opcode(ins_opcode), .ins_imm(ins_imm), .ins_len(ins_len),
    .ins_pc(ins_pc), .halted(halted)
  );

  typedef struct {
    bit [7:0]    op;
    int          len;
    logic [15:0] imm;
    logic [15:0] pc;
  } ins_t;

  bit [7:0]    mem [65536];
  int          n_cmp = 0;
  int          n_bad = 0;

  // reference model state
  bit [7:0]    m_q[$];
  logic [15:0] m_fetch, m_head, m_inf_addr;
  bit          m_inflight, m_stale, m_halted;
  ins_t        log_q[$];
  int          step_no, first_valid, rd_cnt;
  bit          pend_v;
  logic [15:0] pend_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_len(input bit [7:0] op);
    case (op)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
      8'hC3, 8'hCB, 8'hCD, 8'hDD, 8'hED, 8'hFD: return 3;
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hDB, 8'hD3: return 2;
      default: ;
    endcase
    if (op >= 8'hC0 && (op % 8 == 2 || op % 8 == 4)) return 3;  // Jccc / Cccc
    if (op < 8'h40 && op % 8 == 6) return 2;                    // MVI
    return 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ins_ready = 1'b0; redir_valid = 1'b0; redir_pc = 16'h0;
    mem_rdata = 8'h00; pend_v = 1'b0;
    #1;
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ins_opcode", ins_opcode, 0);
    chk("rst_ins_imm", ins_imm, 0);
    chk("rst_ins_len", ins_len, 1);
    chk("rst_ins_pc", ins_pc, 0);
    chk("rst_halted", halted, 0);
    m_q.delete(); m_fetch = 16'h0; m_head = 16'h0; m_inf_addr = 16'h0;
    m_inflight = 0; m_stale = 0; m_halted = 0;
    log_q.delete(); step_no = 0; first_valid = -1; rd_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: compare outputs against the model, drive the inputs for the
  // coming edge, then advance the model across that edge.
  task automatic step(input bit rdy, input bit rv, input logic [15:0] rpc);
    bit          e_rd, e_valid, acc, new_halt;
    int          e_len;
    bit [7:0]    e_op;
    logic [15:0] e_imm;
    @(negedge clk); #1;
    e_rd    = !m_halted && (m_q.size() + int'(m_inflight) < QD);
    e_op    = (m_q.size() > 0) ? m_q[0] : 8'h00;
    e_len   = ref_len(e_op);
    e_valid = !m_halted && (m_q.size() >= e_len);
    e_imm   = 16'h0;
    if (e_valid && e_len == 3) e_imm = {m_q[2], m_q[1]};
    if (e_valid && e_len == 2) e_imm = {8'h00, m_q[1]};

    chk("mem_rd_en", mem_rd_en, e_rd);
    if (e_rd) chk("mem_addr", mem_addr, m_fetch);
    chk("ins_valid", ins_valid, e_valid);
    chk("ins_pc", ins_pc, m_head);
    chk("halted", halted, m_halted);
    if (e_valid) begin
      chk("ins_opcode", ins_opcode, e_op);
      chk("ins_len", ins_len, e_len);
      chk("ins_imm", ins_imm, e_imm);
      if (first_valid < 0) first_valid = step_no;
    end
    if (e_rd) rd_cnt++;

    ins_ready = rdy; redir_valid = rv; redir_pc = rpc;
    mem_rdata = pend_v ? mem[pend_a] : 8'($urandom);
    pend_v = mem_rd_en; pend_a = mem_addr;

    acc = e_valid && rdy;
    new_halt = 0;
    if (acc) log_q.push_back('{e_op, e_len, e_imm, m_head});
    if (rv) begin
      m_q.delete();
      m_inf_addr = m_fetch;
      m_fetch = rpc; m_head = rpc; m_halted = 0; m_stale = 1;
    end else begin
      if (acc) begin
        repeat (e_len) void'(m_q.pop_front());
        m_head = m_head + 16'(e_len);
`ifdef I8080_FETCH_HLT_STOP_EN
        if (e_op == 8'h76) new_halt = 1;
`endif
      end
      if (m_inflight && !m_stale && !m_halted) m_q.push_back(mem[m_inf_addr]);
      if (new_halt) m_halted = 1;
      m_stale = 0;
      m_inf_addr = m_fetch;
      if (e_rd) m_fetch = m_fetch + 16'h1;
    end
    m_inflight = e_rd;
    step_no++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    bit rv, rdy;
    logic [15:0] rpc;

    // Phase 1: NOP stream from reset.
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (12) step(1, 0, 16'h0);
    chk("p1_first_valid", first_valid, 2);
    chk("p1_log_size", log_q.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("p1_pc", log_q[i].pc, i);
      chk("p1_op", log_q[i].op, 0);
      chk("p1_len", log_q[i].len, 1);
      chk("p1_imm", log_q[i].imm, 0);
    end

    // Phase 2: LXI H,1234 then MVI A,55.
    do_reset();
    mem[0] = 8'h21; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'h3E; mem[4] = 8'h55;
    repeat (12) step(1, 0, 16'h0);
    chk("p2_log_size", log_q.size() >= 2, 1);
    chk("p2_lxi_op", log_q[0].op, 8'h21);
    chk("p2_lxi_len", log_q[0].len, 3);
    chk("p2_lxi_imm", log_q[0].imm, 16'h1234);
    chk("p2_lxi_pc", log_q[0].pc, 16'h0000);
    chk("p2_mvi_len", log_q[1].len, 2);
    chk("p2_mvi_imm", log_q[1].imm, 16'h0055);
    chk("p2_mvi_pc", log_q[1].pc, 16'h0003);

    // Phase 3: stall, then redirect with a read in flight.
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h40 + i);
    for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 8'(8'h60 + i);
    repeat (10) step(0, 0, 16'h0);
    chk("p3_stall_reads", rd_cnt, 4);
    step(1, 0, 16'h0);
    n = 0;
    while (!m_inflight && n < 8) begin step(0, 0, 16'h0); n++; end
    chk("p3_inflight_seen", m_inflight, 1);
    base = log_q.size();
    step(0, 1, 16'h0100);
    repeat (10) step(1, 0, 16'h0);
    chk("p3_log_size", log_q.size() > base, 1);
    chk("p3_redir_pc", log_q[base].pc, 16'h0100);
    chk("p3_redir_op", log_q[base].op, 8'h60);
    chk("p3_first_pc", log_q[0].pc, 16'h0000);
    chk("p3_first_op", log_q[0].op, 8'h40);

    // Phase 4: JMP straddling the top of the address space.
    do_reset();
    mem[0] = 8'h00; mem[1] = 8'h20;
    for (int i = 2; i < 10; i++) mem[i] = 8'h40;
    mem[16'hFFFF] = 8'hC3;
    step(0, 1, 16'hFFFF);
    repeat (12) step(1, 0, 16'h0);
    chk("p4_log_size", log_q.size() >= 2, 1);
    chk("p4_jmp_pc", log_q[0].pc, 16'hFFFF);
    chk("p4_jmp_op", log_q[0].op, 8'hC3);
    chk("p4_jmp_len", log_q[0].len, 3);
    chk("p4_jmp_imm", log_q[0].imm, 16'h2000);
    chk("p4_wrap_pc", log_q[1].pc, 16'h0002);

    // Phase 5: HLT.
    do_reset();
    mem[0] = 8'h76;
    for (int i = 1; i < 32; i++) mem[i] = 8'h00;
    repeat (10) step(1, 0, 16'h0);
`ifdef I8080_FETCH_HLT_STOP_EN
    chk("p5_log_size", log_q.size(), 1);
    chk("p5_halted", halted, 1);
    rd_cnt = 0;
    repeat (5) step(1, 0, 16'h0);
    chk("p5_no_reads", rd_cnt, 0);
    step(1, 1, 16'h0010);
    repeat (6) step(1, 0, 16'h0);
    chk("p5_unhalted", halted, 0);
    chk("p5_resume_pc", log_q[1].pc, 16'h0010);
`else
    chk("p5_log_size", log_q.size() >= 2, 1);
    chk("p5_hlt_op", log_q[0].op, 8'h76);
    chk("p5_next_pc", log_q[1].pc, 16'h0001);
    chk("p5_next_op", log_q[1].op, 8'h00);
    chk("p5_halted", halted, 0);
`endif

    // Phase 6: random memory, random ready and redirects.
    do_reset();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (4000) begin
      rv  = ($urandom % 24) == 0;
      rpc = (($urandom % 4) == 0) ? 16'(16'hFFFF - ($urandom % 4)) : 16'($urandom);
      rdy = ($urandom % 4) != 0;
      step(rdy, rv, rpc);
    end
    chk("p6_progress", log_q.size() >= 200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
